// File: rtl/data_memory_ws.sv
// ============================================================================
// data_memory_ws
// ----------------------------------------------------------------------------
// Byte-addressed, big-endian data memory with a configurable number of wait
// states. Accepts byte, halfword and full-word accesses at any byte address,
// answers with a one-cycle Done pulse, and reports rejected accesses with
// Fault. Load data is registered and right-justified.
//
// Ports
//   Clock      in   1           single clock, rising-edge active
//   Reset      in   1           asynchronous, active-high
//   Req        in   1           request strobe, sampled only while Ready=1
//   MemRead    in   1           read qualifier
//   MemWrite   in   1           write qualifier
//   Size       in   2           00 byte, 01 halfword, 10 word, 11 reserved
//   Address    in   ADDR_WIDTH  byte address of the most-significant byte
//   WriteData  in   DATA_WIDTH  store data, right-justified
//   Ready      out  1           idle, a request can be accepted
//   Done       out  1           one-cycle completion pulse
//   Fault      out  1           access rejected (valid with Done)
//   ReadData   out  DATA_WIDTH  registered load result, zero-extended
//
// State table
//   state     | meaning
//   ST_IDLE   | Ready=1, waiting for Req
//   ST_WAIT   | counting down the wait states of the latched request
//   ST_ACCESS | commit write / load / fault on the next edge, pulse Done
// ============================================================================
module data_memory_ws #(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 24,
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Ready,
    output logic                  Done,
    output logic                  Fault,
    output logic [DATA_WIDTH-1:0] ReadData
);

    localparam int BYTES = DATA_WIDTH / 8;
    // Address arithmetic is one bit wider than the bus so that a range
    // running past the top of the address space is seen as out of range
    // instead of wrapping onto low addresses.
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int SH_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [AW1-1:0]   DEPTH_LIM = AW1'(DEPTH_BYTES);
    localparam logic [CNT_W-1:0] CNT_LOAD  = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic                  rd_q;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [7:0] mem [DEPTH_BYTES];

    logic                  accept;
    logic [AW1-1:0]        n_bytes;
    logic [AW1-1:0]        last_addr;
    logic [SH_W-1:0]       shamt;
    logic                  fault;
    logic                  do_write;
    logic [IDX_W-1:0]      lane_addr [BYTES];
    logic [DATA_WIDTH-1:0] rd_just;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] wr_just;

    assign Ready  = (state == ST_IDLE);
    assign accept = Ready && Req;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (Req) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_ACCESS;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture: everything the access needs is frozen at acceptance
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            size_q  <= Size;
            addr_q  <= Address;
            wdata_q <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Access decode on the latched request
    // ------------------------------------------------------------------
    always_comb begin
        n_bytes = AW1'(1);
        shamt   = '0;
        case (size_q)
            2'b00: begin
                n_bytes = AW1'(1);
                shamt   = SH_W'(8 * (BYTES - 1));
            end
            2'b01: begin
                n_bytes = AW1'(2);
                shamt   = SH_W'(8 * (BYTES - 2));
            end
            2'b10: begin
                n_bytes = AW1'(BYTES);
                shamt   = '0;
            end
            default: begin
                n_bytes = AW1'(1);
                shamt   = '0;
            end
        endcase
    end

    assign last_addr = {1'b0, addr_q} + n_bytes - AW1'(1);
    assign fault     = (rd_q == wr_q) || (size_q == 2'b11) || (last_addr >= DEPTH_LIM);
    assign do_write  = (state == ST_ACCESS) && wr_q && !fault;

    // Lane i is the byte at Address+i. The low address bits are enough to
    // index storage because lanes are only used when the range is legal.
    always_comb begin
        for (int i = 0; i < BYTES; i++) begin
            lane_addr[i] = addr_q[IDX_W-1:0] + IDX_W'(i);
        end
    end

    // Data is handled left-justified so lane i always maps to the same bit
    // slice; a single shift converts to/from the right-justified bus.
    always_comb begin
        rd_just = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (AW1'(i) < n_bytes) begin
                rd_just[DATA_WIDTH-1-8*i -: 8] = mem[lane_addr[i]];
            end
        end
    end

    assign rd_data = rd_just >> shamt;
    assign wr_just = wdata_q << shamt;

    // ------------------------------------------------------------------
    // Storage: not reset, contents survive Reset
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (do_write) begin
            for (int i = 0; i < BYTES; i++) begin
                if (AW1'(i) < n_bytes) begin
                    mem[lane_addr[i]] <= wr_just[DATA_WIDTH-1-8*i -: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Done     <= 1'b0;
            Fault    <= 1'b0;
            ReadData <= '0;
        end else begin
            Done  <= 1'b0;
            Fault <= 1'b0;
            if (state == ST_ACCESS) begin
                Done  <= 1'b1;
                Fault <= fault;
                if (fault) begin
                    ReadData <= '0;
                end else if (rd_q) begin
                    ReadData <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// ============================================================================
// tb_data_memory_ws
// ----------------------------------------------------------------------------
// Self-checking bench for data_memory_ws. A byte-array reference model tracks
// storage and the last load result; a request-pattern scheduler predicts
// acceptance and completion edges for the handshake runs on a second
// instance built with two wait states.
// ============================================================================
module tb_data_memory_ws;

    localparam int W1    = 1;
    localparam int W2    = 2;
    localparam int DEPTH = 128;

    logic        Clock = 1'b0;
    logic        Reset;

    logic        Req, MemRead, MemWrite;
    logic [1:0]  Size;
    logic [23:0] Address, WriteData;
    logic        Ready, Done, Fault;
    logic [23:0] ReadData;

    logic        Req2, MemRead2, MemWrite2;
    logic [1:0]  Size2;
    logic [23:0] Address2, WriteData2;
    logic        Ready2, Done2, Fault2;
    logic [23:0] ReadData2;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [23:0] ref_rdata;

    always #5 Clock = ~Clock;

    data_memory_ws #(
        .DATA_WIDTH(24), .ADDR_WIDTH(24), .DEPTH_BYTES(DEPTH), .WAIT_STATES(W1)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .MemRead(MemRead),
        .MemWrite(MemWrite), .Size(Size), .Address(Address),
        .WriteData(WriteData), .Ready(Ready), .Done(Done), .Fault(Fault),
        .ReadData(ReadData)
    );

    data_memory_ws #(
        .DATA_WIDTH(24), .ADDR_WIDTH(24), .DEPTH_BYTES(DEPTH), .WAIT_STATES(W2)
    ) dut2 (
        .Clock(Clock), .Reset(Reset), .Req(Req2), .MemRead(MemRead2),
        .MemWrite(MemWrite2), .Size(Size2), .Address(Address2),
        .WriteData(WriteData2), .Ready(Ready2), .Done(Done2), .Fault(Fault2),
        .ReadData(ReadData2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_n(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit ref_fault(input bit rd, input bit wr, input logic [1:0] sz,
                                     input logic [23:0] ad);
        longint last;
        last = longint'(ad) + longint'(ref_n(sz)) - 1;
        return (rd == wr) || (sz == 2'b11) || (last >= DEPTH);
    endfunction

    function automatic logic [23:0] ref_read(input logic [1:0] sz, input logic [23:0] ad);
        logic [23:0] v;
        v = '0;
        for (int j = 0; j < ref_n(sz); j++) begin
            v = (v << 8) | 24'(ref_mem[int'(ad) + j]);
        end
        return v;
    endfunction

    task automatic ref_write(input logic [1:0] sz, input logic [23:0] ad, input logic [23:0] wd);
        int n;
        n = ref_n(sz);
        for (int j = 0; j < n; j++) begin
            ref_mem[int'(ad) + j] = 8'((wd >> (8 * (n - 1 - j))) & 24'hFF);
        end
    endtask

    // One complete access on the W=1 instance, checked against the model.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz,
                          input logic [23:0] ad, input logic [23:0] wd,
                          output logic [23:0] rdo, output bit flt);
        int  edges;
        bit  exp_f;
        @(negedge Clock);
        chk($sformatf("ready_before@%0h", ad), Ready, 1);
        Req = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; Address = ad; WriteData = wd;
        @(posedge Clock);
        #1;
        // scramble inputs: the access in flight must not notice
        Req = 1'b0;
        Address = 24'($urandom); WriteData = 24'($urandom); Size = 2'($urandom);
        MemRead = 1'($urandom); MemWrite = 1'($urandom);
        chk($sformatf("ready_busy@%0h", ad), Ready, 0);
        edges = 0;
        while (edges < 20) begin
            @(posedge Clock);
            #1;
            edges++;
            if (Done) break;
        end
        chk($sformatf("latency@%0h", ad), edges, W1 + 1);
        exp_f = ref_fault(rd, wr, sz, ad);
        if (exp_f) ref_rdata = '0;
        else if (rd) ref_rdata = ref_read(sz, ad);
        else ref_write(sz, ad, wd);
        chk($sformatf("fault@%0h", ad), Fault, exp_f);
        chk($sformatf("rdata@%0h", ad), ReadData, ref_rdata);
        chk($sformatf("ready_done@%0h", ad), Ready, 1);
        rdo = ReadData;
        flt = Fault;
        @(posedge Clock);
        #1;
        chk($sformatf("done_clear@%0h", ad), Done, 0);
        chk($sformatf("fault_clear@%0h", ad), Fault, 0);
    endtask

    // Drive a 16-edge Req pattern into the W=2 instance (always a faulting
    // request) and compare acceptance / Done / Fault edges with a scheduler.
    task automatic hs_run(input string name, input logic [15:0] pat);
        logic [15:0] obs_acc, obs_done, obs_flt, exp_acc, exp_done;
        int next_free;
        obs_acc = '0; obs_done = '0; obs_flt = '0; exp_acc = '0; exp_done = '0;
        next_free = 0;
        for (int e = 0; e < 16; e++) begin
            if (pat[e] && e >= next_free) begin
                exp_acc[e] = 1'b1;
                next_free  = e + W2 + 2;
                if (e + W2 + 1 < 16) exp_done[e + W2 + 1] = 1'b1;
            end
        end
        for (int e = 0; e < 16; e++) begin
            @(negedge Clock);
            Req2 = pat[e];
            #1;
            if (Ready2 && Req2) obs_acc[e] = 1'b1;
            @(posedge Clock);
            #1;
            obs_done[e] = Done2;
            obs_flt[e]  = Fault2;
            if (Done2) chk({name, "_rdata"}, ReadData2, 0);
        end
        @(negedge Clock);
        Req2 = 1'b0;
        repeat (W2 + 3) @(posedge Clock);
        chk({name, "_accept"}, obs_acc, exp_acc);
        chk({name, "_done"},   obs_done, exp_done);
        chk({name, "_fault"},  obs_flt, exp_done);
    endtask

    initial begin
        logic [23:0] rdo;
        bit          flt;
        bit          rd, wr;
        logic [1:0]  sz;
        logic [23:0] ad;
        int          r;

        Reset = 1'b1;
        Req = 0; MemRead = 0; MemWrite = 0; Size = 0; Address = 0; WriteData = 0;
        Req2 = 0; MemRead2 = 1; MemWrite2 = 0; Size2 = 2'b11; Address2 = 0; WriteData2 = 0;
        ref_rdata = '0;

        repeat (2) @(posedge Clock);
        #1;
        chk("rst_ready", Ready, 1);
        chk("rst_done", Done, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_rdata", ReadData, 0);
        @(negedge Clock);
        Reset = 1'b0;

        // define every byte so the model knows the contents
        for (int a = 0; a < DEPTH; a++) begin
            access(0, 1, 2'b00, 24'(a), 24'($urandom), rdo, flt);
        end

        // word write / read and big-endian byte placement
        access(0, 1, 2'b10, 24'h10, 24'hA1B2C3, rdo, flt);
        access(1, 0, 2'b10, 24'h10, 24'h0, rdo, flt);
        chk("word_rd", rdo, 24'hA1B2C3);
        access(1, 0, 2'b00, 24'h10, 24'h0, rdo, flt);
        chk("byte10", rdo, 24'h0000A1);
        access(1, 0, 2'b00, 24'h12, 24'h0, rdo, flt);
        chk("byte12", rdo, 24'h0000C3);

        // sub-word write, then wider reads
        access(0, 1, 2'b00, 24'h11, 24'hFFFF5A, rdo, flt);
        chk("wr_keeps_rdata", rdo, 24'h0000C3);
        access(1, 0, 2'b10, 24'h10, 24'h0, rdo, flt);
        chk("word_after_byte", rdo, 24'hA15AC3);
        access(1, 0, 2'b01, 24'h11, 24'h0, rdo, flt);
        chk("half11", rdo, 24'h005AC3);

        // top-of-memory boundary
        access(1, 0, 2'b10, 24'h7D, 24'h0, rdo, flt);
        chk("word7D_ok", flt, 0);
        access(0, 1, 2'b10, 24'h7E, 24'h112233, rdo, flt);
        chk("word7E_fault", flt, 1);
        chk("word7E_rdata", rdo, 0);
        access(1, 0, 2'b01, 24'h7E, 24'h0, rdo, flt);
        access(1, 0, 2'b01, 24'hFFFFFF, 24'h0, rdo, flt);
        chk("wrap_fault", flt, 1);

        // illegal requests
        access(1, 0, 2'b10, 24'h10, 24'h0, rdo, flt);
        access(1, 1, 2'b10, 24'h20, 24'h445566, rdo, flt);
        chk("rdwr_fault", flt, 1);
        access(0, 0, 2'b00, 24'h20, 24'h0, rdo, flt);
        chk("none_fault", flt, 1);
        access(0, 1, 2'b11, 24'h20, 24'h778899, rdo, flt);
        chk("size11_fault", flt, 1);
        access(1, 0, 2'b10, 24'h20, 24'h0, rdo, flt);

        // randomized traffic
        for (int k = 0; k < 80; k++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            r  = int'($urandom_range(0, 9));
            ad = (r == 0) ? 24'($urandom) : 24'($urandom_range(0, DEPTH + 3));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      begin rd = 1; wr = 1; end
            else if (r == 1) begin rd = 0; wr = 0; end
            else if (r < 6)  begin rd = 1; wr = 0; end
            else             begin rd = 0; wr = 1; end
            access(rd, wr, sz, ad, 24'($urandom), rdo, flt);
        end

        // handshake on the two-wait-state instance
        hs_run("hold10", 16'h03FF);
        hs_run("busy_pulses", 16'h0007);
        hs_run("rand_req", 16'($urandom));

        // reset in the middle of a write
        @(negedge Clock);
        Req = 1; MemRead = 0; MemWrite = 1; Size = 2'b10; Address = 24'h20; WriteData = 24'h123456;
        @(posedge Clock);
        #1;
        Req = 0;
        chk("midrst_busy", Ready, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        chk("midrst_ready", Ready, 1);
        chk("midrst_done", Done, 0);
        chk("midrst_fault", Fault, 0);
        chk("midrst_rdata", ReadData, 0);
        ref_rdata = '0;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        access(1, 0, 2'b10, 24'h20, 24'h0, rdo, flt);
        chk("midrst_contents", rdo, ref_read(2'b10, 24'h20));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
